cell_histogram_accum: RTL and testbench

Vertical accumulator for HOG cell histograms. Consumes the stream of 9-bin row histograms (one per 8-pixel cell-row segment, raster order) and sums CELL_ROWS consecutive segments of the same cell column. The result is one 9-bin cell histogram per cell. It sits directly downstream of the row-histogram stage and feeds block normalisation.

---
 rtl/hog_pkg.sv | 24 ++
 rtl/hist_bin_adder.sv | 37 +++
 rtl/cell_histogram_accum.sv | 105 ++++++++++
 tb/tb_cell_histogram_accum.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hog_pkg.sv
// Shared HOG definitions: bin count, default bin widths, cell FSM states and
// the packed-bin slicing helper used by the row and cell histogram stages.
package hog_pkg;
  localparam int HOG_NUM_BINS       = 9;
  localparam int HOG_BIN_WIDTH      = 11;
  localparam int HOG_CELL_BIN_WIDTH = 14;
  localparam int HOG_MAX_LANE_W     = 32;
  localparam int HOG_MAX_VEC_W      = HOG_NUM_BINS * HOG_MAX_LANE_W;

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_FINAL = 1'b1
  } cell_state_e;

  // Returns bin k of a packed vector of w-bit lanes, zero-extended to 32 bits.
  function automatic logic [HOG_MAX_LANE_W-1:0] hog_bin(
    input logic [HOG_MAX_VEC_W-1:0] vec,
    input int unsigned              k,
    input int unsigned              w
  );
    return HOG_MAX_LANE_W'(vec >> (k * w)) &
           HOG_MAX_LANE_W'((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/hist_bin_adder.sv
// 9-lane combinational histogram adder: CELL_BIN_WIDTH lanes + BIN_WIDTH lanes.
// Lanes wrap modulo 2^CELL_BIN_WIDTH unless CELL_HIST_SAT_EN is defined.
module hist_bin_adder
  import hog_pkg::*;
#(
  parameter int BIN_WIDTH      = HOG_BIN_WIDTH,
  parameter int CELL_BIN_WIDTH = HOG_CELL_BIN_WIDTH
) (
  input  logic [CELL_BIN_WIDTH*HOG_NUM_BINS-1:0] i_a,
  input  logic [BIN_WIDTH*HOG_NUM_BINS-1:0]      i_b,
  output logic [CELL_BIN_WIDTH*HOG_NUM_BINS-1:0] o_sum
);
  localparam int SUM_W = ((CELL_BIN_WIDTH > BIN_WIDTH) ? CELL_BIN_WIDTH : BIN_WIDTH) + 1;

  function automatic logic [CELL_BIN_WIDTH-1:0] lane_limit(input logic [SUM_W-1:0] s);
`ifdef CELL_HIST_SAT_EN
    if (s > SUM_W'({CELL_BIN_WIDTH{1'b1}}))
      return {CELL_BIN_WIDTH{1'b1}};
    return s[CELL_BIN_WIDTH-1:0];
`else
    return s[CELL_BIN_WIDTH-1:0];
`endif
  endfunction

  logic [HOG_MAX_VEC_W-1:0] w_a_ext;
  logic [HOG_MAX_VEC_W-1:0] w_b_ext;

  assign w_a_ext = HOG_MAX_VEC_W'(i_a);
  assign w_b_ext = HOG_MAX_VEC_W'(i_b);

  for (genvar k = 0; k < HOG_NUM_BINS; k++) begin : g_lane
    logic [SUM_W-1:0] w_sum_lane;
    assign w_sum_lane = SUM_W'(hog_bin(w_a_ext, k, CELL_BIN_WIDTH)) +
                        SUM_W'(hog_bin(w_b_ext, k, BIN_WIDTH));
    assign o_sum[k*CELL_BIN_WIDTH +: CELL_BIN_WIDTH] = lane_limit(w_sum_lane);
  end
endmodule

// File: rtl/cell_histogram_accum.sv
// Vertical HOG cell accumulator: sums CELL_ROWS row histograms per cell column.
// Optional lane saturation is selected with the CELL_HIST_SAT_EN macro.
module cell_histogram_accum
  import hog_pkg::*;
#(
  parameter int BIN_WIDTH      = HOG_BIN_WIDTH,
  parameter int CELL_BIN_WIDTH = HOG_CELL_BIN_WIDTH,
  parameter int CELLS_PER_ROW  = 80,
  parameter int CELL_ROWS      = 8,
  parameter int IN_HIST_WIDTH  = BIN_WIDTH * HOG_NUM_BINS,
  parameter int OUT_HIST_WIDTH = CELL_BIN_WIDTH * HOG_NUM_BINS,
  localparam int COL_W         = $clog2(CELLS_PER_ROW),
  localparam int ROW_W         = $clog2(CELL_ROWS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_HIST_WIDTH-1:0]  row_histogram,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_HIST_WIDTH-1:0] cell_histogram,
  output logic [COL_W-1:0]          cell_col
);
  logic [COL_W-1:0]          r_col_cnt;
  logic [ROW_W-1:0]          r_row_cnt;
  cell_state_e               r_state;
  logic [OUT_HIST_WIDTH-1:0] r_mem [CELLS_PER_ROW];
  logic                      r_out_valid;
  logic [OUT_HIST_WIDTH-1:0] r_cell_hist;
  logic [COL_W-1:0]          r_cell_col;

  logic                      w_xfer;
  logic                      w_col_last;
  logic                      w_row_last;
  logic                      w_row_prefinal;
  logic [OUT_HIST_WIDTH-1:0] w_stored;
  logic [OUT_HIST_WIDTH-1:0] w_sum;

  assign in_ready       = (r_state == S_ACCUM) || !r_out_valid || out_ready;
  assign w_xfer         = in_valid && in_ready && !frame_start;
  assign w_col_last     = (r_col_cnt == COL_W'(CELLS_PER_ROW - 1));
  assign w_row_last     = (r_row_cnt == ROW_W'(CELL_ROWS - 1));
  assign w_row_prefinal = (r_row_cnt == ROW_W'(CELL_ROWS - 2));

  // Row 0 starts a fresh cell, so whatever the column slot held is discarded.
  assign w_stored = (r_row_cnt == '0) ? '0 : r_mem[r_col_cnt];

  hist_bin_adder #(
    .BIN_WIDTH      (BIN_WIDTH),
    .CELL_BIN_WIDTH (CELL_BIN_WIDTH)
  ) u_adder (
    .i_a   (w_stored),
    .i_b   (row_histogram),
    .o_sum (w_sum)
  );

  // Stage p0: counters, cell FSM and the registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_cnt   <= '0;
      r_row_cnt   <= '0;
      r_state     <= S_ACCUM;
      r_out_valid <= 1'b0;
      r_cell_hist <= '0;
      r_cell_col  <= '0;
    end else begin
      if (frame_start) begin
        r_col_cnt <= '0;
        r_row_cnt <= '0;
        r_state   <= S_ACCUM;
      end else if (w_xfer) begin
        if (w_col_last) begin
          r_col_cnt <= '0;
          r_row_cnt <= w_row_last ? '0 : r_row_cnt + ROW_W'(1);
          case (r_state)
            S_ACCUM: if (w_row_prefinal) r_state <= S_FINAL;
            S_FINAL: r_state <= S_ACCUM;
            default: r_state <= S_ACCUM;
          endcase
        end else begin
          r_col_cnt <= r_col_cnt + COL_W'(1);
        end
      end

      if (w_xfer && (r_state == S_FINAL)) begin
        r_out_valid <= 1'b1;
        r_cell_hist <= w_sum;
        r_cell_col  <= r_col_cnt;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer && (r_state == S_ACCUM))
      r_mem[r_col_cnt] <= w_sum;
  end

  assign out_valid      = r_out_valid;
  assign cell_histogram = r_cell_hist;
  assign cell_col       = r_cell_col;
endmodule

// File: tb/tb_cell_histogram_accum.sv
// Bench for cell_histogram_accum: a 14-bit and a 10-bit lane instance share the
// same stimulus and are checked against a per-cell arithmetic reference model.
module tb_cell_histogram_accum;
  localparam int CPR  = 4;
  localparam int CR   = 8;
  localparam int BW   = 11;
  localparam int CW   = 14;
  localparam int CW10 = 10;
  localparam int NB   = 9;
  localparam int IW   = BW * NB;
  localparam int OW   = CW * NB;
  localparam int OW10 = CW10 * NB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [IW-1:0] row_histogram = '0;
  logic in_ready, out_valid, in_ready10, out_valid10;
  logic [OW-1:0]   cell_histogram;
  logic [OW10-1:0] cell_histogram10;
  logic [1:0] cell_col, cell_col10;

  always #5 clk = ~clk;

  cell_histogram_accum #(
    .BIN_WIDTH(BW), .CELL_BIN_WIDTH(CW), .CELLS_PER_ROW(CPR), .CELL_ROWS(CR)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .in_ready(in_ready), .row_histogram(row_histogram), .out_valid(out_valid),
    .out_ready(out_ready), .cell_histogram(cell_histogram), .cell_col(cell_col)
  );

  cell_histogram_accum #(
    .BIN_WIDTH(BW), .CELL_BIN_WIDTH(CW10), .CELLS_PER_ROW(CPR), .CELL_ROWS(CR)
  ) dut10 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .in_ready(in_ready10), .row_histogram(row_histogram), .out_valid(out_valid10),
    .out_ready(out_ready), .cell_histogram(cell_histogram10), .cell_col(cell_col10)
  );

  int total = 0;
  int bad = 0;
  int n = 0;
  int msum [CPR][NB];
  logic [OW-1:0]   q14 [$];
  logic [OW10-1:0] q10 [$];
  int              qcol [$];
  int g_hold = 0;
  bit g_rand = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lane10(input int s);
`ifdef CELL_HIST_SAT_EN
    return (s > 1023) ? 1023 : s;
`else
    return s % 1024;
`endif
  endfunction

  function automatic logic [IW-1:0] fill(input int v);
    logic [IW-1:0] h = '0;
    for (int k = 0; k < NB; k++) h[k*BW +: BW] = BW'(v);
    return h;
  endfunction

  function automatic logic [IW-1:0] one_bin(input int k, input int v);
    logic [IW-1:0] h = '0;
    h[k*BW +: BW] = BW'(v);
    return h;
  endfunction

  // One clock: drive at negedge, check just after, update the model at posedge.
  task automatic cycle(input bit v, input logic [IW-1:0] h, input bit fs, output bit acc);
    bit ordy, erdy, pend;
    int col, row, b;
    logic [OW-1:0] e14;
    logic [OW10-1:0] e10;
    @(negedge clk);
    if (g_hold > 0) begin
      ordy = 1'b0;
      g_hold--;
    end else begin
      ordy = g_rand ? bit'($urandom_range(0, 1)) : 1'b1;
    end
    in_valid = v; row_histogram = h; frame_start = fs; out_ready = ordy;
    #1;
    row  = (n / CPR) % CR;
    pend = (qcol.size() != 0);
    erdy = !(row == CR - 1 && pend && !ordy);
    chk("in_ready", in_ready, erdy);
    chk("in_ready10", in_ready10, erdy);
    chk("out_valid", out_valid, pend);
    chk("out_valid10", out_valid10, pend);
    if (pend) begin
      chk("cell_col", cell_col, qcol[0]);
      chk("cell_col10", cell_col10, qcol[0]);
      chk("cell_hist", cell_histogram, q14[0]);
      chk("cell_hist10", cell_histogram10, q10[0]);
      if (ordy) begin
        void'(qcol.pop_front()); void'(q14.pop_front()); void'(q10.pop_front());
      end
    end
    acc = v && erdy && !fs;
    @(posedge clk);
    if (fs) begin
      n = 0;
    end else if (acc) begin
      col = n % CPR;
      for (int k = 0; k < NB; k++) begin
        b = int'(h[k*BW +: BW]);
        msum[col][k] = (row == 0) ? b : msum[col][k] + b;
      end
      if (row == CR - 1) begin
        for (int k = 0; k < NB; k++) begin
          e14[k*CW +: CW]     = CW'(msum[col][k]);
          e10[k*CW10 +: CW10] = CW10'(lane10(msum[col][k]));
        end
        q14.push_back(e14); q10.push_back(e10); qcol.push_back(col);
      end
      n = (n + 1) % (CPR * CR);
    end
  endtask

  task automatic send(input logic [IW-1:0] h);
    bit acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) cycle(1'b1, h, 1'b0, acc);
    if (!acc) begin
      total++; bad++;
      $error("FAIL send_timeout observed=stalled expected=accepted");
    end
  endtask

  task automatic idle(input int cycles);
    bit acc;
    for (int i = 0; i < cycles; i++) cycle(1'b0, '0, 1'b0, acc);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_valid10", out_valid10, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_cell_col", cell_col, 2'd0);
    chk("rst_cell_hist", cell_histogram, '0);
    chk("rst_cell_hist10", cell_histogram10, '0);
    n = 0;
    qcol.delete(); q14.delete(); q10.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit acc;
    logic [IW-1:0] h;
    apply_reset();

    // Constant all-ones input: four cells of value 8.
    repeat (32) send(fill(1));
    idle(2);

    // Column-distinct bin0 over two cell rows.
    for (int i = 0; i < 64; i++) send(one_bin(0, (i % CPR) + 1));
    idle(2);

    // Output stalled through the final row.
    repeat (28) send(fill(3));
    g_hold = 8;
    repeat (4) send(fill(3));
    idle(2);

    // frame_start after 10 inputs, with a competing valid input.
    repeat (10) send(fill(5));
    cycle(1'b1, fill(7), 1'b1, acc);
    repeat (32) send(fill(1));
    idle(2);

    // Reset during row 5, then all-255 cells (2040 / 10-bit lane overflow).
    repeat (22) send(fill(2));
    apply_reset();
    repeat (32) send(fill(255));
    idle(2);

    // Randomized traffic with gaps, backpressure and occasional frame_start.
    g_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NB; k++) h[k*BW +: BW] = BW'($urandom_range(0, 2040));
      cycle($urandom_range(0, 3) != 0, h, $urandom_range(0, 99) == 0, acc);
    end
    g_rand = 1'b0;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
